// File: rtl/logic_axi4_stream_arbiter.sv
// rtl/logic_axi4_stream_arbiter.sv - packet-granular round-robin arbiter onto one registered stream sink
module logic_axi4_stream_arbiter #(
    parameter int INPUTS   = 2,
    parameter int WIDTH    = 1,
    parameter int ID_WIDTH = $clog2(INPUTS)
) (
    input  logic                      aclk,
    input  logic                      areset_n,
    input  logic [INPUTS-1:0]         rx_tvalid,
    input  logic [INPUTS-1:0]         rx_tlast,
    input  logic [INPUTS*WIDTH-1:0]   rx_tdata,
    output logic [INPUTS-1:0]         rx_tready,
    output logic                      tx_tvalid,
    output logic                      tx_tlast,
    output logic [WIDTH-1:0]          tx_tdata,
    output logic [ID_WIDTH-1:0]       tx_tid,
    input  logic                      tx_tready
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t              state;
    logic [ID_WIDTH-1:0] grant;
    logic [ID_WIDTH-1:0] pointer;
    logic [ID_WIDTH-1:0] next_grant;
    logic [ID_WIDTH-1:0] grant_wrap;
    logic [ID_WIDTH-1:0] hi_idx;
    logic [ID_WIDTH-1:0] lo_idx;
    logic                hi_found;
    logic                lo_found;
    logic                can_load;
    logic                accept;
    logic                sel_tvalid;
    logic                sel_tlast;
    logic [WIDTH-1:0]    sel_tdata;

    assign can_load = !tx_tvalid || tx_tready;

    // Ready is a function of state and the output register only, never of rx_tvalid.
    always_comb begin
        rx_tready  = '0;
        sel_tdata  = '0;
        sel_tlast  = 1'b0;
        sel_tvalid = 1'b0;
        for (int i = 0; i < INPUTS; i++) begin
            if (grant == ID_WIDTH'(i)) begin
                rx_tready[i] = (state == LOCKED) && can_load;
                sel_tdata    = rx_tdata[i*WIDTH +: WIDTH];
                sel_tlast    = rx_tlast[i];
                sel_tvalid   = rx_tvalid[i];
            end
        end
    end

    assign accept = sel_tvalid && (state == LOCKED) && can_load;

    // Circular search: first requester at or above pointer, else the lowest one.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (rx_tvalid[i] && !lo_found) begin
                lo_found = 1'b1;
                lo_idx   = ID_WIDTH'(i);
            end
            if (rx_tvalid[i] && !hi_found && (ID_WIDTH'(i) >= pointer)) begin
                hi_found = 1'b1;
                hi_idx   = ID_WIDTH'(i);
            end
        end
        next_grant = hi_found ? hi_idx : lo_idx;
    end

    assign grant_wrap = (grant == ID_WIDTH'(INPUTS - 1)) ? '0 : grant + ID_WIDTH'(1);

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            state     <= IDLE;
            grant     <= '0;
            pointer   <= '0;
            tx_tvalid <= 1'b0;
            tx_tlast  <= 1'b0;
            tx_tdata  <= '0;
            tx_tid    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lo_found) begin
                        grant <= next_grant;
                        state <= LOCKED;
                    end
                end
                LOCKED: begin
                    if (accept && sel_tlast) begin
                        state   <= IDLE;
                        pointer <= grant_wrap;
                    end
                end
                default: state <= IDLE;
            endcase

            if (accept) begin
                tx_tvalid <= 1'b1;
                tx_tdata  <= sel_tdata;
                tx_tlast  <= sel_tlast;
                tx_tid    <= grant;
            end else if (can_load) begin
                tx_tvalid <= 1'b0;
            end
        end
    end

    a_ready_onehot: assert property (@(posedge aclk) disable iff (!areset_n)
        $onehot0(rx_tready));

    a_tx_stable: assert property (@(posedge aclk) disable iff (!areset_n)
        (tx_tvalid && !tx_tready) |=>
        (tx_tvalid && $stable(tx_tdata) && $stable(tx_tlast) && $stable(tx_tid)));

endmodule
